// File: rtl/core_pkg.sv
// Shared RV32I decode types: opcodes, ALU ops, immediate formats and the D/X register layout.
package core_pkg;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_FENCE  = 7'b0001111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic [2:0]  funct3;
    logic        op_a_pc;
    logic        op_b_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic        illegal;
  } dx_reg_t;

  localparam dx_reg_t DX_BUBBLE = '{
    pc: 32'd0, rd: 5'd0, imm: 32'd0, alu_op: ALU_ADD, funct3: 3'd0,
    op_a_pc: 1'b0, op_b_imm: 1'b0, reg_write: 1'b0, mem_read: 1'b0,
    mem_write: 1'b0, branch: 1'b0, jump: 1'b0, jalr: 1'b0, illegal: 1'b0
  };

  function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_fmt_e fmt);
    case (fmt)
      IMM_S:   return {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   return {inst[31:12], 12'b0};
      IMM_J:   return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: return {{20{inst[31]}}, inst[31:20]};
    endcase
  endfunction

  // alt selects SUB/SRA; callers only raise it where that encoding is meaningful
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32I decoder: instruction word to D/X fields plus register-use flags.
module decode_comb
  import core_pkg::*;
#(
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output dx_reg_t     dx,
  output logic        use_rs1,
  output logic        use_rs2
);

  logic [2:0] f3;
  logic [6:0] f7;
  logic       illegal;
  logic       writes_rd;

  assign f3 = inst[14:12];
  assign f7 = inst[31:25];

  always_comb begin
    dx        = DX_BUBBLE;
    dx.pc     = pc;
    dx.funct3 = f3;
    illegal   = 1'b0;
    writes_rd = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;

    case (inst[6:0])
      OPC_LUI: begin
        dx.imm = imm_gen(inst, IMM_U);
        dx.alu_op = ALU_PASS_B;
        dx.op_b_imm = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        dx.imm = imm_gen(inst, IMM_U);
        dx.op_a_pc = 1'b1;
        dx.op_b_imm = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_JAL: begin
        dx.imm = imm_gen(inst, IMM_J);
        dx.op_a_pc = 1'b1;
        dx.op_b_imm = 1'b1;
        dx.jump = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_JALR: begin
        dx.imm = imm_gen(inst, IMM_I);
        dx.op_b_imm = 1'b1;
        dx.jump = 1'b1;
        dx.jalr = 1'b1;
        writes_rd = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        dx.imm = imm_gen(inst, IMM_B);
        dx.alu_op = ALU_SUB;
        dx.branch = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        dx.imm = imm_gen(inst, IMM_I);
        dx.op_b_imm = 1'b1;
        dx.mem_read = 1'b1;
        writes_rd = 1'b1;
        use_rs1 = 1'b1;
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        dx.imm = imm_gen(inst, IMM_S);
        dx.op_b_imm = 1'b1;
        dx.mem_write = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        illegal = (f3 >= 3'b011);
      end
      OPC_OP_IMM: begin
        dx.imm = imm_gen(inst, IMM_I);
        dx.alu_op = alu_from_f3(f3, (f3 == 3'b101) && inst[30]);
        dx.op_b_imm = 1'b1;
        writes_rd = 1'b1;
        use_rs1 = 1'b1;
        illegal = ((f3 == 3'b001) || (f3 == 3'b101)) && (f7 != 7'h00) && (f7 != 7'h20);
      end
      OPC_OP: begin
        dx.alu_op = alu_from_f3(f3, inst[30]);
        writes_rd = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        illegal = ((f7 != 7'h00) && (f7 != 7'h20)) ||
                  ((f7 == 7'h20) && (f3 != 3'b000) && (f3 != 3'b101));
      end
      OPC_FENCE, OPC_SYSTEM: dx.funct3 = 3'd0;
      default: illegal = 1'b1;
    endcase

    if (writes_rd) begin
      dx.rd = inst[11:7];
      dx.reg_write = (inst[11:7] != 5'd0);
    end

    // The all-zero word is how fetch marks a flushed slot, not an illegal opcode
    if (inst == 32'd0) begin
      dx = DX_BUBBLE;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
    end else if (illegal) begin
      if (ILLEGAL_AS_NOP) begin
        dx = DX_BUBBLE;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
      end
      dx.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: D/X pipeline register with flush/stall priority and load-use hazard detection.
module decode_stage
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic            load_use_stall_o,
  output logic [XLEN-1:0] d_pc_o,
  output logic [4:0]      d_rd_o,
  output logic [XLEN-1:0] d_imm_o,
  output logic [3:0]      d_alu_op_o,
  output logic [2:0]      d_funct3_o,
  output logic            d_op_a_pc_o,
  output logic            d_op_b_imm_o,
  output logic            d_reg_write_o,
  output logic            d_mem_read_o,
  output logic            d_mem_write_o,
  output logic            d_branch_o,
  output logic            d_jump_o,
  output logic            d_jalr_o,
  output logic            d_illegal_o
);

  dx_reg_t dec;
  dx_reg_t dx_q;
  logic    use_rs1;
  logic    use_rs2;

  decode_comb #(.ILLEGAL_AS_NOP(ILLEGAL_AS_NOP)) u_decode_comb (
    .inst    (inst_i),
    .pc      (pc_i),
    .dx      (dec),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );

  assign rs1_addr_o = inst_i[19:15];
  assign rs2_addr_o = inst_i[24:20];

  // Stays high under stall_i so fetch keeps holding even though D/X is frozen
  assign load_use_stall_o = !flush_i && dx_q.mem_read && (dx_q.rd != 5'd0) &&
                            ((use_rs1 && (rs1_addr_o == dx_q.rd)) ||
                             (use_rs2 && (rs2_addr_o == dx_q.rd)));

  always_ff @(posedge clk_i) begin
    if (rst_i)                 dx_q <= DX_BUBBLE;
    else if (flush_i)          dx_q <= DX_BUBBLE;
    else if (stall_i)          dx_q <= dx_q;
    else if (load_use_stall_o) dx_q <= DX_BUBBLE;
    else                       dx_q <= dec;
  end

  assign d_pc_o        = dx_q.pc;
  assign d_rd_o        = dx_q.rd;
  assign d_imm_o       = dx_q.imm;
  assign d_alu_op_o    = dx_q.alu_op;
  assign d_funct3_o    = dx_q.funct3;
  assign d_op_a_pc_o   = dx_q.op_a_pc;
  assign d_op_b_imm_o  = dx_q.op_b_imm;
  assign d_reg_write_o = dx_q.reg_write;
  assign d_mem_read_o  = dx_q.mem_read;
  assign d_mem_write_o = dx_q.mem_write;
  assign d_branch_o    = dx_q.branch;
  assign d_jump_o      = dx_q.jump;
  assign d_jalr_o      = dx_q.jalr;
  assign d_illegal_o   = dx_q.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second pipeline stage of the in-order RV32I core.
- Consumes the 32-bit instruction word registered by the fetch stage. That word is all-zero after a flush.
- Decodes the word into register addresses, a sign-extended immediate, an ALU opcode and control flags, then registers them into the D/X pipeline register.
- Detects load-use hazards against the instruction already in D/X. On a hazard it requests a fetch stall and inserts a bubble.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- ILLEGAL_AS_NOP, 1, when 1 an illegal encoding enters D/X as a bubble with d_illegal_o set; when 0 its fields pass through unchanged.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- inst_i  in  32  instruction word from fetch; 0 denotes a bubble.
- pc_i  in  32  PC of inst_i.
- stall_i  in  1  downstream stall; D/X register holds.
- flush_i  in  1  branch taken or execute jump; D/X loads a bubble.
- rs1_addr_o  out  5  combinational inst_i[19:15], to the register file.
- rs2_addr_o  out  5  combinational inst_i[24:20], to the register file.
- load_use_stall_o  out  1  combinational hazard request, OR'd into fetch and PC stall.
- d_pc_o  out  32  registered PC.
- d_rd_o  out  5  destination register.
- d_imm_o  out  32  sign-extended immediate.
- d_alu_op_o  out  4  alu_op_e.
- d_funct3_o  out  3  for branch and memory width.
- d_op_a_pc_o  out  1  operand A = PC (AUIPC, JAL).
- d_op_b_imm_o  out  1  operand B = immediate.
- d_reg_write_o  out  1  write rd.
- d_mem_read_o  out  1  load.
- d_mem_write_o  out  1  store.
- d_branch_o  out  1  conditional branch.
- d_jump_o  out  1  JAL or JALR.
- d_jalr_o  out  1  JALR.
- d_illegal_o  out  1  illegal opcode or funct encoding.

Behaviour:
- Reset (rst_i=1 at a clock edge): every d_* output goes to 0, which is a bubble. The combinational outputs follow inst_i.
- Bubble definition: all d_* control flags are 0, d_rd_o=0, d_imm_o=0, d_alu_op_o=ALU_ADD, d_pc_o=0.
- Latency: one cycle from inst_i to d_* outputs.
- D/X register update priority, highest first, at each rising edge:
  - rst_i.
  - flush_i: load a bubble.
  - stall_i: hold all fields.
  - load_use_stall_o: load a bubble.
  - Otherwise: load the decoded inst_i.
- Load-use hazard: load_use_stall_o = d_mem_read_o AND d_rd_o != 0 AND ((inst_i uses rs1 AND rs1 == d_rd_o) OR (inst_i uses rs2 AND rs2 == d_rd_o)).
  - rs1 is used by OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - rs2 is used by OP, STORE, BRANCH.
  - Forced to 0 while flush_i=1.
  - Still asserted while stall_i=1; the D/X register holds anyway.
- Hazard resolution: the hazard clears one cycle after the bubble enters D/X. The stalled instruction is then captured.
- inst_i=0x00000000: decoded as a bubble, with d_illegal_o=0.
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE, SYSTEM. FENCE and SYSTEM decode as a NOP.
- Illegal encodings:
  - Any other opcode.
  - funct7 other than 0x00/0x20 on OP, or 0x20 with funct3 other than ADD/SRL.
  - Shift-immediate with inst[31:25] other than 0x00/0x20.
  - Branch funct3 010/011.
  - Load funct3 011/110/111.
  - Store funct3 ≥ 011.
- Immediate formats (I/S/B/U/J): per RV32I, sign bit always inst[31]. B and J immediates have bit 0 = 0. U immediate = {inst[31:12], 12'b0}.
- ALU opcode and operand select:
  - LUI: ALU_PASS_B.
  - AUIPC, JAL, JALR, LOAD, STORE: ALU_ADD.
  - BRANCH: ALU_SUB.
  - JAL and JALR: d_reg_write_o=1 (link).
- rd=x0: d_reg_write_o=0 regardless of opcode.

Decomposition:
- Package core_pkg holds:
  - opcode_e: 7-bit localparams.
  - alu_op_e: 4-bit; ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B.
  - imm_fmt_e: I, S, B, U, J.
  - dx_reg_t: packed struct of all d_* fields.
  - DX_BUBBLE: a dx_reg_t constant.
- One sub-module, decode_comb: purely combinational inst → dx_reg_t plus rs-use flags.
- decode_stage owns the register, the priority logic and hazard detection.

Test Plan:
- Reset, then inst_i=0x00500093 (addi x1,x0,5) → next cycle: d_rd_o=1, d_imm_o=5, d_alu_op_o=ADD, d_op_b_imm_o=1, d_reg_write_o=1.
- inst_i=0x0000A103 (lw x2,0(x1)), then 0x001101B3 (add x3,x2,x1):
  - load_use_stall_o=1 for exactly one cycle.
  - D/X holds a bubble for that cycle.
  - The add is captured the following cycle with d_rd_o=3.
- inst_i=0xFFDFF0EF (jal x1,-4) → d_imm_o=0xFFFFFFFC, d_jump_o=1, d_op_a_pc_o=1, d_reg_write_o=1.
- flush_i=1 and stall_i=1 together with a valid inst_i → D/X becomes a bubble (flush wins); load_use_stall_o=0.
- stall_i=1 for 3 cycles with inst_i changing → d_* outputs remain constant.
- inst_i=0xFFFFFFFF → d_illegal_o=1, all other control flags 0 (ILLEGAL_AS_NOP=1). Then inst_i=0x00000000 → d_illegal_o=0.
